shift_add_multiplier: RTL



---
 rtl/shift_add_multiplier.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// Unsigned shift/add multiplier with valid/ready handshakes on the operand and result sides.
// Define SHIFT_ADD_MULT_EARLY_TERM_EN to finish early once no multiplier bits remain.

module ripple_carry_adder #(
   parameter int NUMBITS = 16
) (
   input  logic [NUMBITS-1:0] a,
   input  logic [NUMBITS-1:0] b,
   input  logic               carryin,
   output logic [NUMBITS-1:0] sum,
   output logic               carryout
);

   logic [NUMBITS:0] carry;

   always_comb begin
      carry[0] = carryin;
      for (int i = 0; i < NUMBITS; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      carryout = carry[NUMBITS];
   end

endmodule

module shift_add_multiplier #(
   parameter int NUMBITS = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NUMBITS-1:0]     a,
   input  logic [NUMBITS-1:0]     b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*NUMBITS-1:0]   product,
   output logic                   busy
);

   localparam int CW = $clog2(NUMBITS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUMBITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state, next_state;
   logic [NUMBITS-1:0]     m;
   logic [NUMBITS-1:0]     r;
   logic [2*NUMBITS-1:0]   p;
   logic [CW-1:0]          cnt;
   logic [NUMBITS-1:0]     add_b;
   logic [NUMBITS-1:0]     sum;
   logic                   carryout;

   assign add_b = r[0] ? m : '0;

   ripple_carry_adder #(.NUMBITS(NUMBITS)) u_adder (
      .a        (p[2*NUMBITS-1:NUMBITS]),
      .b        (add_b),
      .carryin  (1'b0),
      .sum      (sum),
      .carryout (carryout)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (in_valid) next_state = RUN;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
         RUN:  if (cnt == LAST || r == '0) next_state = DONE;
`else
         RUN:  if (cnt == LAST) next_state = DONE;
`endif
         DONE: if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
   // Remaining right shifts still owed once the multiplier has run out of set bits.
   logic [CW-1:0] shamt;
   assign shamt = CW'(NUMBITS) - cnt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m   <= '0;
         r   <= '0;
         p   <= '0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  m   <= a;
                  r   <= b;
                  p   <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
               if (r == '0) begin
                  p <= p >> shamt;
               end else
`endif
               begin
                  // Carryout lands in the MSB so the full 2N-bit product survives.
                  p   <= {carryout, sum, p[NUMBITS-1:1]};
                  r   <= r >> 1;
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == RUN);
   assign out_valid = (state == DONE);
   assign product   = p;

endmodule
